// File: rtl/xm_bus_arbiter_if.sv
// Shared Wishbone classic bundle between two requesters, the arbiter and one slave.
// Latency: none, signal bundle only.
// Backpressure: carried by the slave ack; the arbiter adds a one-cycle grant delay.
interface xm_bus_arbiter_if #(
  parameter int WORD = 16,
  parameter int ADDR = WORD - (WORD / 8) + 1
);
  // Master 0 (CPU memory controller port)
  logic              m0_cyc_i;
  logic              m0_stb_i;
  logic              m0_we_i;
  logic [WORD/8-1:0] m0_sel_i;
  logic [ADDR-1:0]   m0_adr_i;
  logic [WORD-1:0]   m0_dat_i;
  logic              m0_ack_o;
  logic              m0_err_o;
  logic [WORD-1:0]   m0_dat_o;
  // Master 1 (DMA / debug requester)
  logic              m1_cyc_i;
  logic              m1_stb_i;
  logic              m1_we_i;
  logic [WORD/8-1:0] m1_sel_i;
  logic [ADDR-1:0]   m1_adr_i;
  logic [WORD-1:0]   m1_dat_i;
  logic              m1_ack_o;
  logic              m1_err_o;
  logic [WORD-1:0]   m1_dat_o;
  // Shared slave side
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [WORD/8-1:0] s_sel_o;
  logic [ADDR-1:0]   s_adr_o;
  logic [WORD-1:0]   s_dat_o;
  logic              s_ack_i;
  logic [WORD-1:0]   s_dat_i;
  // One-hot current owner
  logic [1:0]        gnt_o;

  // Arbiter view: receives requests and slave responses, drives the shared bus.
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    output m0_ack_o, m0_err_o, m0_dat_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    output m1_ack_o, m1_err_o, m1_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_ack_i, s_dat_i,
    output gnt_o
  );

  // Requester/slave-device view: drives requests and slave responses.
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
    input  m0_ack_o, m0_err_o, m0_dat_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
    input  m1_ack_o, m1_err_o, m1_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_ack_i, s_dat_i,
    input  gnt_o
  );
endinterface

// File: rtl/xm_bus_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with cycle lock and bus-timeout abort.
// Latency: 1 cycle from cyc to grant; data/ack paths are combinational through the owner mux.
// Backpressure: slave ack passes straight to the owner; a hung strobe is aborted with err after TIMEOUT cycles.
module xm_bus_arbiter #(
  parameter int WORD    = 16,
  parameter int ADDR    = WORD - (WORD / 8) + 1,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic               clk_i,
  input  logic               arst_i,
  xm_bus_arbiter_if.slave    bus
);
  localparam int            SEL     = WORD / 8;
  localparam logic [TW-1:0] TMO_CNT = TW'(TIMEOUT);
  localparam bit            WD_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, ABORT = 2'd3} state_t;

  state_t        state_q;
  // last_q doubles as the owner index: it is written on every grant and holds through ABORT.
  logic          last_q;
  logic [TW-1:0] cnt_q;

  logic            own_cyc, own_stb, own_we;
  logic [SEL-1:0]  own_sel;
  logic [ADDR-1:0] own_adr;
  logic [WORD-1:0] own_dat;
  logic            owning;
  logic            tmo;

  // Select the owning master's request lines.
  always_comb begin
    if (last_q) begin
      own_cyc = bus.m1_cyc_i;
      own_stb = bus.m1_stb_i;
      own_we  = bus.m1_we_i;
      own_sel = bus.m1_sel_i;
      own_adr = bus.m1_adr_i;
      own_dat = bus.m1_dat_i;
    end else begin
      own_cyc = bus.m0_cyc_i;
      own_stb = bus.m0_stb_i;
      own_we  = bus.m0_we_i;
      own_sel = bus.m0_sel_i;
      own_adr = bus.m0_adr_i;
      own_dat = bus.m0_dat_i;
    end
  end

  assign owning = (state_q == OWN0) || (state_q == OWN1);
  // Terminal count with no ack this cycle; a coincident ack wins and suppresses the error.
  assign tmo = WD_EN && owning && own_cyc && own_stb && !bus.s_ack_i && (cnt_q == TMO_CNT);

  // Bus mux: only an owning state connects a master to the slave; IDLE and ABORT park everything at 0.
  always_comb begin
    bus.s_cyc_o  = 1'b0;
    bus.s_stb_o  = 1'b0;
    bus.s_we_o   = 1'b0;
    bus.s_sel_o  = '0;
    bus.s_adr_o  = '0;
    bus.s_dat_o  = '0;
    bus.m0_ack_o = 1'b0;
    bus.m0_err_o = 1'b0;
    bus.m0_dat_o = '0;
    bus.m1_ack_o = 1'b0;
    bus.m1_err_o = 1'b0;
    bus.m1_dat_o = '0;
    if (owning) begin
      bus.s_cyc_o = own_cyc;
      bus.s_stb_o = own_stb;
      bus.s_we_o  = own_we;
      bus.s_sel_o = own_sel;
      bus.s_adr_o = own_adr;
      bus.s_dat_o = own_dat;
      if (last_q) begin
        bus.m1_ack_o = bus.s_ack_i;
        bus.m1_err_o = tmo;
        bus.m1_dat_o = bus.s_dat_i;
      end else begin
        bus.m0_ack_o = bus.s_ack_i;
        bus.m0_err_o = tmo;
        bus.m0_dat_o = bus.s_dat_i;
      end
    end
    bus.gnt_o = (state_q == IDLE) ? 2'b00 : (last_q ? 2'b10 : 2'b01);
  end

  // Ownership FSM with round-robin tie break and stalled-strobe watchdog.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_q)) begin
            state_q <= OWN0;
            last_q  <= 1'b0;
          end else if (bus.m1_cyc_i) begin
            state_q <= OWN1;
            last_q  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (tmo) begin
            state_q <= ABORT;
            cnt_q   <= '0;
          end else if (WD_EN && own_stb && !bus.s_ack_i) begin
            cnt_q <= cnt_q + TW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ABORT: begin
          cnt_q <= '0;
          if (!own_cyc) state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xm_bus_arbiter.sv
// Directed bench for the two-master arbiter: reset, grant latency, round robin, lock, read path, timeout, async reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: slave ack is driven by hand per cycle.
module tb_xm_bus_arbiter;
  logic clk_i = 1'b0;
  logic arst_i = 1'b0;
  int checks = 0;
  int errors = 0;

  xm_bus_arbiter_if #(.WORD(16)) bus ();

  xm_bus_arbiter #(.WORD(16), .TIMEOUT(4), .TW(8)) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0; bus.m0_we_i = 1'b0;
    bus.m0_sel_i = '0;   bus.m0_adr_i = '0;   bus.m0_dat_i = '0;
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.m1_we_i = 1'b0;
    bus.m1_sel_i = '0;   bus.m1_adr_i = '0;   bus.m1_dat_i = '0;
    bus.s_ack_i  = 1'b0; bus.s_dat_i  = '0;
  endtask

  task automatic test_reset();
    arst_i = 1'b0;
    clear_inputs();
    bus.s_dat_i = 16'hFFFF;
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    repeat (2) @(posedge clk_i);
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", bus.s_cyc_o); end
    checks++; if (bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b want 0", bus.s_stb_o); end
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt_o); end
    checks++; if (bus.m0_dat_o !== 16'h0000) begin errors++; $display("FAIL reset_m0_dat: got %h want 0000", bus.m0_dat_o); end
    checks++; if (bus.m1_dat_o !== 16'h0000) begin errors++; $display("FAIL reset_m1_dat: got %h want 0000", bus.m1_dat_o); end
    checks++; if (bus.m0_ack_o !== 1'b0 || bus.m0_err_o !== 1'b0) begin errors++; $display("FAIL reset_m0_ack_err: got %b%b want 00", bus.m0_ack_o, bus.m0_err_o); end
    clear_inputs();
    step();
    arst_i = 1'b1;
  endtask

  task automatic test_single_master();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_we_i = 1'b1;
    bus.m0_sel_i = 2'b11; bus.m0_adr_i = 15'h1234; bus.m0_dat_i = 16'hBEEF;
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_latency: s_cyc got %b want 0 in request cycle", bus.s_cyc_o); end
    step(); sample();
    checks++; if (bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL single_s_cyc: got %b want 1", bus.s_cyc_o); end
    checks++; if (bus.s_adr_o !== 15'h1234) begin errors++; $display("FAIL single_s_adr: got %h want 1234", bus.s_adr_o); end
    checks++; if (bus.s_dat_o !== 16'hBEEF) begin errors++; $display("FAIL single_s_dat: got %h want beef", bus.s_dat_o); end
    checks++; if (bus.s_we_o !== 1'b1) begin errors++; $display("FAIL single_s_we: got %b want 1", bus.s_we_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b want 01", bus.gnt_o); end
    checks++; if (bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL single_no_ack: got %b want 0", bus.m0_ack_o); end
    step();
    bus.s_ack_i = 1'b1;
    sample();
    checks++; if (bus.m0_ack_o !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", bus.m0_ack_o); end
    checks++; if (bus.m1_ack_o !== 1'b0) begin errors++; $display("FAIL single_m1_ack: got %b want 0", bus.m1_ack_o); end
    step();
    clear_inputs();
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b00 || bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_release: gnt %b s_cyc %b want 00 0", bus.gnt_o, bus.s_cyc_o); end
  endtask

  task automatic test_round_robin();
    step();
    arst_i = 1'b0;
    #2;
    arst_i = 1'b1;
    bus.m0_cyc_i = 1'b1; bus.m1_cyc_i = 1'b1;
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rr_tie_first: got %b want 01", bus.gnt_o); end
    step();
    bus.m0_cyc_i = 1'b0;
    sample();
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap: got %b want 00", bus.gnt_o); end
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second: got %b want 10", bus.gnt_o); end
    step();
    bus.m0_cyc_i = 1'b1;
    sample();
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL rr_no_preempt: got %b want 10", bus.gnt_o); end
    step();
    bus.m1_cyc_i = 1'b0;
    sample();
    step();
    bus.m1_cyc_i = 1'b1;
    sample();
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL rr_idle_gap2: got %b want 00", bus.gnt_o); end
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL rr_alternate: got %b want 01", bus.gnt_o); end
    step();
    clear_inputs();
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL rr_release: got %b want 00", bus.gnt_o); end
  endtask

  task automatic test_lock_read();
    step();
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b0;
    bus.m1_sel_i = 2'b11; bus.m1_adr_i = 15'h0042;
    step();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.s_ack_i = 1'b1; bus.s_dat_i = 16'hA5C3;
    sample();
    checks++; if (bus.m1_dat_o !== 16'hA5C3) begin errors++; $display("FAIL read_m1_dat: got %h want a5c3", bus.m1_dat_o); end
    checks++; if (bus.m0_dat_o !== 16'h0000) begin errors++; $display("FAIL read_m0_dat: got %h want 0000", bus.m0_dat_o); end
    checks++; if (bus.s_adr_o !== 15'h0042 || bus.s_we_o !== 1'b0) begin errors++; $display("FAIL read_s_adr_we: got %h %b want 0042 0", bus.s_adr_o, bus.s_we_o); end
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin step(); sample(); end
      checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want 10", i, bus.gnt_o); end
      checks++; if (bus.m1_ack_o !== 1'b1 || bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL lock_acks[%0d]: m1 %b m0 %b want 1 0", i, bus.m1_ack_o, bus.m0_ack_o); end
    end
    step();
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0; bus.s_ack_i = 1'b0;
    sample();
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL lock_idle: got %b want 00", bus.gnt_o); end
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b01 || bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL lock_handover: gnt %b s_cyc %b want 01 1", bus.gnt_o, bus.s_cyc_o); end
    step();
    clear_inputs();
    step(); sample();
  endtask

  task automatic test_timeout();
    step();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_sel_i = 2'b01; bus.m0_adr_i = 15'h0100;
    for (int i = 1; i <= 4; i++) begin
      step(); sample();
      checks++; if (bus.m0_err_o !== 1'b0 || bus.s_cyc_o !== 1'b1) begin errors++; $display("FAIL tmo_wait[%0d]: err %b s_cyc %b want 0 1", i, bus.m0_err_o, bus.s_cyc_o); end
    end
    step(); sample();
    checks++; if (bus.m0_err_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1 in 5th strobe cycle", bus.m0_err_o); end
    checks++; if (bus.m0_ack_o !== 1'b0) begin errors++; $display("FAIL tmo_ack: got %b want 0", bus.m0_ack_o); end
    step();
    bus.m1_cyc_i = 1'b1;
    sample();
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL abort_bus: s_cyc %b s_stb %b want 0 0", bus.s_cyc_o, bus.s_stb_o); end
    checks++; if (bus.m0_err_o !== 1'b0) begin errors++; $display("FAIL abort_err_pulse: got %b want 0", bus.m0_err_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL abort_gnt: got %b want 01", bus.gnt_o); end
    step();
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    sample();
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL abort_hold: got %b want 01", bus.gnt_o); end
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL abort_idle: got %b want 00", bus.gnt_o); end
    step(); sample();
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL abort_m1_grant: got %b want 10", bus.gnt_o); end
    step();
    clear_inputs();
    step(); sample();
  endtask

  task automatic test_ack_at_limit_async_reset();
    step();
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 15'h0200;
    for (int i = 1; i <= 4; i++) begin
      step(); sample();
      checks++; if (bus.m1_err_o !== 1'b0) begin errors++; $display("FAIL limit_wait[%0d]: err %b want 0", i, bus.m1_err_o); end
    end
    step();
    bus.s_ack_i = 1'b1;
    sample();
    checks++; if (bus.m1_err_o !== 1'b0 || bus.m1_ack_o !== 1'b1) begin errors++; $display("FAIL limit_ack_wins: err %b ack %b want 0 1", bus.m1_err_o, bus.m1_ack_o); end
    step();
    bus.s_ack_i = 1'b0;
    sample();
    checks++; if (bus.gnt_o !== 2'b10 || bus.s_cyc_o !== 1'b1 || bus.m1_err_o !== 1'b0) begin errors++; $display("FAIL limit_still_own: gnt %b s_cyc %b err %b want 10 1 0", bus.gnt_o, bus.s_cyc_o, bus.m1_err_o); end
    #2;
    arst_i = 1'b0;
    #1;
    checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL async_rst_bus: s_cyc %b s_stb %b want 0 0", bus.s_cyc_o, bus.s_stb_o); end
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL async_rst_gnt: got %b want 00", bus.gnt_o); end
    clear_inputs();
    step();
    arst_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_round_robin();
    test_lock_read();
    test_timeout();
    test_ack_at_limit_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
